// File: rtl/clock_divider_multi.sv
// NUM_CH programmable clock divider channels sharing one valid/ready config slot.
// Optional macro CLKDIV_SYNC_EN adds sync_start to phase-align all enabled channels.
module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 28,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 0,
    parameter int RESET_EN    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_start,
`endif
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] ch_tick
);

    localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);

    logic              pending_reg;
    logic [CH_W-1:0]   pch_reg;
    logic [CNT_W-1:0]  pdiv_reg;
    logic              pen_reg;
    logic              err_reg;
    logic [NUM_CH-1:0] apply;
    logic              accept;
    logic              ch_ok;
    logic              sync;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_start;
`else
    assign sync = 1'b0;
`endif

    assign cfg_ready = ~pending_reg;
    assign cfg_err   = err_reg;
    assign accept    = cfg_valid & ~pending_reg;
    assign ch_ok     = 32'(cfg_ch) < NUM_CH_U;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= 1'b0;
            pch_reg     <= '0;
            pdiv_reg    <= '0;
            pen_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= accept & ~ch_ok;
            if (pending_reg && (apply != '0)) begin
                pending_reg <= 1'b0;
            end else if (accept && ch_ok) begin
                pending_reg <= 1'b1;
                pch_reg     <= cfg_ch;
                pdiv_reg    <= cfg_div;
                pen_reg     <= cfg_en;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] div_reg;
            logic             en_reg;
            logic             clk_reg;
            logic             tick_reg;
            logic             at_bound;

            assign at_bound = (cnt_reg == div_reg);
            // A disabled target takes its config at once; an enabled one waits for its boundary.
            assign apply[gi] = pending_reg && (pch_reg == CH_W'(gi)) && (!en_reg || at_bound);
            assign ch_clk[gi]  = clk_reg;
            assign ch_tick[gi] = tick_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg  <= '0;
                    div_reg  <= CNT_W'(DEFAULT_DIV);
                    en_reg   <= (RESET_EN != 0);
                    clk_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else begin
                    tick_reg <= 1'b0;
                    if (!en_reg || sync) begin
                        cnt_reg <= '0;
                        clk_reg <= 1'b0;
                    end else if (at_bound) begin
                        cnt_reg  <= '0;
                        clk_reg  <= (apply[gi] && !pen_reg) ? 1'b0 : ~clk_reg;
                        tick_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (apply[gi]) begin
                        div_reg <= pdiv_reg;
                        en_reg  <= pen_reg;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: reset, divisor/enable changes, handshake stalls,
// bad channel, reset with a pending request, max divisor and (optionally) sync_start.
module tb_clock_divider_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_err;
    logic [NUM_CH-1:0] ch_clk;
    logic [NUM_CH-1:0] ch_tick;
`ifdef CLKDIV_SYNC_EN
    logic              sync_start = 1'b0;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ticks3 = 0;

    clock_divider_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_DIV(0), .RESET_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_err(cfg_err),
`ifdef CLKDIV_SYNC_EN
        .sync_start(sync_start),
`endif
        .ch_clk(ch_clk), .ch_tick(ch_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
        $display("check %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic cfg(input int ch, input int dv, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_en    = en;
    endtask

    initial begin
        #2;
        chk("rst_clk", 32'(ch_clk), 0);
        chk("rst_tick", 32'(ch_tick), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_err", 32'(cfg_err), 0);
        step();
        reset_n = 1'b1;
        cyc = 0;

        // all channels at div=0: clk/2, tick every cycle
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("div0_clk", 32'(ch_clk), cyc[0] ? 32'hF : 32'h0);
            chk("div0_tick", 32'(ch_tick), 32'hF);
        end

        // ch1 -> div=4, applied at the next boundary
        cfg(1, 4, 1'b1);
        step();
        chk("t2_ready_lo", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        step();
        chk("t2_ready_hi", 32'(cfg_ready), 1);
        chk("t2_apply_clk1", 32'(ch_clk[1]), 0);
        chk("t2_apply_tick1", 32'(ch_tick[1]), 1);
        for (int c = 7; c <= 16; c++) begin
            step();
            chk("t2_clk1", 32'(ch_clk[1]), ((cyc - 6) / 5) % 2);
            chk("t2_tick1", 32'(ch_tick[1]), ((cyc - 6) % 5) == 0 ? 1 : 0);
            chk("t2_clk0", 32'(ch_clk[0]), cyc % 2);
        end

        // ch2 -> div=9, then disable while cnt=3
        step();
        cfg(2, 9, 1'b1);
        step();
        chk("t3_ready_lo", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        step();
        chk("t3_ready_hi", 32'(cfg_ready), 1);
        chk("t3_clk2_hi", 32'(ch_clk[2]), 1);
        chk("t3_tick2", 32'(ch_tick[2]), 1);
        step();
        step();
        cfg(2, 0, 1'b0);
        for (int c = 22; c <= 28; c++) begin
            step();
            cfg_valid = 1'b0;
            chk("t3_ready_stall", 32'(cfg_ready), 0);
            chk("t3_clk2_run", 32'(ch_clk[2]), 1);
            chk("t3_clk0", 32'(ch_clk[0]), cyc % 2);
        end
        step();
        chk("t3_off_clk2", 32'(ch_clk[2]), 0);
        chk("t3_off_tick2", 32'(ch_tick[2]), 1);
        chk("t3_off_ready", 32'(cfg_ready), 1);
        step();
        chk("t3_held_clk2", 32'(ch_clk[2]), 0);
        chk("t3_held_tick2", 32'(ch_tick[2]), 0);

        // back-to-back requests to ch3: div=2, then div=1
        cfg(3, 2, 1'b1);
        step();
        chk("t4_ready_a", 32'(cfg_ready), 0);
        cfg(3, 1, 1'b1);
        step();
        chk("t4_ready_apply_a", 32'(cfg_ready), 1);
        chk("t4_clk3_a", 32'(ch_clk[3]), 0);
        chk("t4_tick3_a", 32'(ch_tick[3]), 1);
        step();
        cfg_valid = 1'b0;
        chk("t4_ready_b", 32'(cfg_ready), 0);
        chk("t4_clk3_c1", 32'(ch_clk[3]), 0);
        chk("t4_tick3_c1", 32'(ch_tick[3]), 0);
        step();
        chk("t4_ready_b2", 32'(cfg_ready), 0);
        chk("t4_clk3_c2", 32'(ch_clk[3]), 0);
        step();
        chk("t4_ready_apply_b", 32'(cfg_ready), 1);
        chk("t4_clk3_b", 32'(ch_clk[3]), 1);
        chk("t4_tick3_b", 32'(ch_tick[3]), 1);
        step();
        chk("t4_clk3_b1", 32'(ch_clk[3]), 1);
        chk("t4_tick3_b1", 32'(ch_tick[3]), 0);
        step();
        chk("t4_clk3_b2", 32'(ch_clk[3]), 0);
        chk("t4_tick3_b2", 32'(ch_tick[3]), 1);

        // out-of-range channel
        chk("t5_err_idle", 32'(cfg_err), 0);
        cfg(5, 3, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("t5_err_pulse", 32'(cfg_err), 1);
        chk("t5_ready", 32'(cfg_ready), 1);
        step();
        chk("t5_err_clear", 32'(cfg_err), 0);
        chk("t5_ready2", 32'(cfg_ready), 1);
        chk("t5_clk3", 32'(ch_clk[3]), 1);

        // reset while a request is pending
        step();
        step();
        cfg(1, 0, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("t6_pending", 32'(cfg_ready), 0);
        step();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_clk", 32'(ch_clk), 0);
        chk("t6_rst_tick", 32'(ch_tick), 0);
        chk("t6_rst_ready", 32'(cfg_ready), 1);
        step();
        chk("t6_rst_hold", 32'(ch_clk), 0);
        reset_n = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("t6_post_clk", 32'(ch_clk), cyc[0] ? 32'hF : 32'h0);
            chk("t6_post_ready", 32'(cfg_ready), 1);
        end

        // disable ch2 at its boundary, then re-enable with div=3 (applies at once)
        cfg(2, 0, 1'b0);
        step();
        cfg_valid = 1'b0;
        step();
        chk("t7_off_clk2", 32'(ch_clk[2]), 0);
        chk("t7_off_tick2", 32'(ch_tick[2]), 1);
        cfg(2, 3, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("t7_pend_ready", 32'(cfg_ready), 0);
        chk("t7_pend_clk2", 32'(ch_clk[2]), 0);
        chk("t7_pend_tick2", 32'(ch_tick[2]), 0);
        step();
        chk("t7_apply_ready", 32'(cfg_ready), 1);
        chk("t7_apply_clk2", 32'(ch_clk[2]), 0);
        for (int c = 8; c <= 10; c++) begin
            step();
            chk("t7_count_clk2", 32'(ch_clk[2]), 0);
            chk("t7_count_tick2", 32'(ch_tick[2]), 0);
        end
        step();
        chk("t7_first_clk2", 32'(ch_clk[2]), 1);
        chk("t7_first_tick2", 32'(ch_tick[2]), 1);

        // maximum divisor on ch3
        cfg(3, 255, 1'b1);
        step();
        cfg_valid = 1'b0;
        step();
        chk("t8_apply_clk3", 32'(ch_clk[3]), 1);
        chk("t8_apply_tick3", 32'(ch_tick[3]), 1);
        while (cyc < 268) begin
            step();
            if (ch_tick[3]) ticks3++;
        end
        chk("t8_no_tick3", 32'(ticks3), 0);
        chk("t8_hold_clk3", 32'(ch_clk[3]), 1);
        step();
        chk("t8_wrap_clk3", 32'(ch_clk[3]), 0);
        chk("t8_wrap_tick3", 32'(ch_tick[3]), 1);

`ifdef CLKDIV_SYNC_EN
        sync_start = 1'b1;
        step();
        sync_start = 1'b0;
        chk("t9_sync_clk", 32'(ch_clk), 0);
        chk("t9_sync_tick", 32'(ch_tick), 0);
        step();
        chk("t9_phase_clk", 32'(ch_clk), 32'h3);
        chk("t9_phase_tick", 32'(ch_tick), 32'h3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
